// File: rtl/alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter
//
// Shares one 8-bit ALU (a, b, cmd, enb -> 16-bit out) between NUM_REQ
// requesters. A round-robin arbiter picks a requester in IDLE and accepts its
// operands with a one-hot req_ready strobe. The operands are registered and
// applied to the ALU for exactly one EXEC cycle. The ALU result is then
// registered together with the owner's index and held in RESP until the
// consumer takes it.
//
// Optional build macro: ALU_ARB_HIPRI_EN
//   defined   : requester 0 has strict priority over all others and does not
//               move the round-robin pointer; requesters 1..NUM_REQ-1 rotate.
//   undefined : pure round-robin across all requesters.
//
// Ports:
//   clk        in   1           rising-edge clock
//   rst_n      in   1           asynchronous active-low reset
//   req_valid  in   NUM_REQ     per-requester request valid
//   req_a      in   NUM_REQ*8   operand A, requester i at [8i+7:8i]
//   req_b      in   NUM_REQ*8   operand B, same packing
//   req_cmd    in   NUM_REQ*4   ALU command, requester i at [4i+3:4i]
//   req_ready  out  NUM_REQ     one-hot accept strobe (IDLE only)
//   rsp_valid  out  1           result available
//   rsp_ready  in   1           consumer accepts result
//   rsp_data   out  16          captured ALU result
//   rsp_id     out  ID_W        index of the requester owning rsp_data
//   alu_a      out  8           ALU operand a
//   alu_b      out  8           ALU operand b
//   alu_cmd    out  4           ALU command
//   alu_enb    out  1           ALU enable (high during EXEC only)
//   alu_out    in   16          ALU result (combinational)
// -----------------------------------------------------------------------------
module alu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_a,
    input  logic [NUM_REQ*8-1:0]   req_b,
    input  logic [NUM_REQ*4-1:0]   req_cmd,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [15:0]            rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    output logic [3:0]             alu_cmd,
    output logic                   alu_enb,
    input  logic [15:0]            alu_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;

    logic [ID_W-1:0]      rr_ptr_r;
    logic [ID_W-1:0]      id_r;
    logic [ID_W-1:0]      ptr_nxt_s;
    logic [ID_W-1:0]      grant_idx_s;
    logic                 grant_found_s;
    logic [NUM_REQ-1:0]   rr_mask_s;
    logic [NUM_REQ-1:0]   req_ready_s;

    logic [7:0]           sel_a_s;
    logic [7:0]           sel_b_s;
    logic [3:0]           sel_cmd_s;

    logic [7:0]           alu_a_r;
    logic [7:0]           alu_b_r;
    logic [3:0]           alu_cmd_r;
    logic                 alu_enb_r;
    logic                 rsp_valid_r;
    logic [15:0]          rsp_data_r;
    logic [ID_W-1:0]      rsp_id_r;

    // Requests that take part in the rotating search.
    always_comb begin
        rr_mask_s = req_valid;
`ifdef ALU_ARB_HIPRI_EN
        // Requester 0 is handled by the priority override, not the rotation.
        rr_mask_s[0] = 1'b0;
`endif
    end

    // Grant search: first pass covers rr_ptr..NUM_REQ-1, second pass wraps to 0..rr_ptr-1.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found_s && rr_mask_s[i] && (i >= int'(rr_ptr_r))) begin
                grant_found_s = 1'b1;
                grant_idx_s   = ID_W'(i);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found_s && rr_mask_s[i] && (i < int'(rr_ptr_r))) begin
                grant_found_s = 1'b1;
                grant_idx_s   = ID_W'(i);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
`ifdef ALU_ARB_HIPRI_EN
        if (req_valid[0]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = '0;
        end else begin
            grant_found_s = grant_found_s;
        end
`endif
    end

    // Pointer to load on a grant: one past the winner, wrapping at NUM_REQ.
    always_comb begin
        if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = grant_idx_s + ID_W'(1);
        end
`ifdef ALU_ARB_HIPRI_EN
        // A priority grant to requester 0 must not disturb the rotation.
        if (grant_idx_s == '0) begin
            ptr_nxt_s = rr_ptr_r;
        end else begin
            ptr_nxt_s = ptr_nxt_s;
        end
`endif
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a_s   = 8'd0;
        sel_b_s   = 8'd0;
        sel_cmd_s = 4'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_s == ID_W'(i)) begin
                sel_a_s   = req_a[8*i +: 8];
                sel_b_s   = req_b[8*i +: 8];
                sel_cmd_s = req_cmd[4*i +: 4];
            end else begin
                sel_a_s = sel_a_s;
            end
        end
    end

    // One-hot accept strobe; forced low while reset is asserted.
    always_comb begin
        req_ready_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst_n && (state_r == ST_IDLE) && grant_found_s &&
                (grant_idx_s == ID_W'(i))) begin
                req_ready_s[i] = 1'b1;
            end else begin
                req_ready_s[i] = 1'b0;
            end
        end
    end

    // Next-state logic for IDLE -> EXEC -> RESP -> IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_found_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath registers: operand capture, ALU enable, response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r    <= '0;
            id_r        <= '0;
            alu_a_r     <= 8'd0;
            alu_b_r     <= 8'd0;
            alu_cmd_r   <= 4'd0;
            alu_enb_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 16'd0;
            rsp_id_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        alu_a_r   <= sel_a_s;
                        alu_b_r   <= sel_b_s;
                        alu_cmd_r <= sel_cmd_s;
                        id_r      <= grant_idx_s;
                        rr_ptr_r  <= ptr_nxt_s;
                        alu_enb_r <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    // Full 16-bit capture keeps the MUL high byte intact.
                    alu_enb_r   <= 1'b0;
                    rsp_data_r  <= alu_out;
                    rsp_id_r    <= id_r;
                    rsp_valid_r <= 1'b1;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    alu_enb_r   <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_id    = rsp_id_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_cmd   = alu_cmd_r;
    assign alu_enb   = alu_enb_r;

endmodule
